// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: sizes,
// state encoding and the operation select used by processor decode.
package multdiv_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_CNT_W = 6;

    localparam logic [MD_WIDTH-1:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_DONE = 2'b11
    } md_state_e;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_MUL  = 2'b01,
        OP_DIV  = 2'b10
    } md_op_e;

    // A start is only valid when exactly one of the two strobes is raised.
    function automatic md_op_e decode_op(input logic mult, input logic div);
        md_op_e op;
        op = OP_NONE;
        if (mult && !div) begin
            op = OP_MUL;
        end else if (div && !mult) begin
            op = OP_DIV;
        end
        return op;
    endfunction

endpackage

// File: rtl/multdiv_unit_div_step.sv
// One restoring-division step on unsigned magnitudes. The caller supplies
// the partial remainder already shifted left with the next dividend bit.
module multdiv_unit_div_step
    import multdiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic [WIDTH:0]   shifted_rem,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);

    logic [WIDTH-1:0] diff;

    // Trial subtract; when it succeeds the true difference is below the
    // divisor, so the low WIDTH bits hold it exactly.
    always_comb begin
        q_bit    = (shifted_rem >= {1'b0, divisor});
        diff     = shifted_rem[WIDTH-1:0] - divisor;
        next_rem = q_bit ? diff : shifted_rem[WIDTH-1:0];
    end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-2 Booth) and divide (restoring) unit.
// One operation per start strobe, fixed latency of WIDTH steps, with a
// one-cycle ready strobe and registered result/exception.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH-1);

    md_state_e          state;
    md_op_e             op_sel;
    logic [CNT_W-1:0]   counter;

    logic [2*WIDTH:0]   booth_acc;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH:0]     booth_hi_ext;
    logic [WIDTH:0]     booth_sum;
    logic [2*WIDTH:0]   booth_next;
    logic [2*WIDTH-1:0] product;
    logic               mul_ovf;

    logic [WIDTH-1:0]   div_rem;
    logic [WIDTH-1:0]   div_quo;
    logic [WIDTH-1:0]   div_mag_b;
    logic               div_neg;
    logic               div_by_zero;
    logic               div_ovf;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   div_rem_next;
    logic               div_q_bit;
    logic [WIDTH-1:0]   quo_next;
    logic [WIDTH-1:0]   quo_signed;

    // Decode the start strobes; both high together counts as no start.
    always_comb begin
        op_sel = decode_op(ctrl_MULT, ctrl_DIV);
    end

    // Booth step: add/subtract the multiplicand in WIDTH+1 bits so the
    // sign shifted in stays correct even for the most negative multiplicand.
    always_comb begin
        booth_hi_ext = {booth_acc[2*WIDTH], booth_acc[2*WIDTH:WIDTH+1]};
        booth_sum    = booth_hi_ext;
        case (booth_acc[1:0])
            2'b01:   booth_sum = booth_hi_ext + {mcand[WIDTH-1], mcand};
            2'b10:   booth_sum = booth_hi_ext - {mcand[WIDTH-1], mcand};
            default: booth_sum = booth_hi_ext;
        endcase
        booth_next = {booth_sum, booth_acc[WIDTH:1]};
        product    = booth_next[2*WIDTH:1];
        mul_ovf    = !((&product[2*WIDTH-1:WIDTH-1]) || (~|product[2*WIDTH-1:WIDTH-1]));
    end

    // Operand magnitudes for division and the signed final quotient.
    always_comb begin
        mag_a      = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        mag_b      = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
        quo_next   = {div_quo[WIDTH-2:0], div_q_bit};
        quo_signed = div_neg ? -quo_next : quo_next;
    end

    multdiv_unit_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .shifted_rem ({div_rem, div_quo[WIDTH-1]}),
        .divisor     (div_mag_b),
        .next_rem    (div_rem_next),
        .q_bit       (div_q_bit)
    );

    // Control FSM and datapath registers; a valid start in any state
    // aborts whatever is running and begins the new operation.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= S_IDLE;
            counter        <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            booth_acc      <= '0;
            mcand          <= '0;
            div_rem        <= '0;
            div_quo        <= '0;
            div_mag_b      <= '0;
            div_neg        <= 1'b0;
            div_by_zero    <= 1'b0;
            div_ovf        <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (op_sel == OP_MUL) begin
                state     <= S_MUL;
                counter   <= '0;
                mcand     <= data_operandA;
                booth_acc <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
            end else if (op_sel == OP_DIV) begin
                state       <= S_DIV;
                counter     <= '0;
                div_rem     <= '0;
                div_quo     <= mag_a;
                div_mag_b   <= mag_b;
                div_neg     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                div_by_zero <= (data_operandB == '0);
                div_ovf     <= (data_operandA == MIN_VAL) && (data_operandB == '1);
            end else begin
                case (state)
                    S_MUL: begin
                        booth_acc <= booth_next;
                        counter   <= counter + 1'b1;
                        if (counter == LAST_STEP) begin
                            state          <= S_DONE;
                            data_result    <= product[WIDTH-1:0];
                            data_exception <= mul_ovf;
                            data_resultRDY <= 1'b1;
                        end
                    end
                    S_DIV: begin
                        div_rem <= div_rem_next;
                        div_quo <= quo_next;
                        counter <= counter + 1'b1;
                        if (counter == LAST_STEP) begin
                            state          <= S_DONE;
                            data_result    <= div_by_zero ? '0 : quo_signed;
                            data_exception <= div_by_zero | div_ovf;
                            data_resultRDY <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_multdiv_unit;
    import multdiv_pkg::*;

    localparam int LAT = 32;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_res;
    logic        last_exc;

    multdiv_unit dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    // Free-running 100 MHz clock.
    always #5 clock = ~clock;

    // Safety net so the run always ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: exact signed arithmetic on 64-bit integers.
    function automatic void modelOp(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output logic exc);
        int     sa;
        int     sb;
        longint p;
        sa = signed'(a);
        sb = signed'(b);
        if (!is_div) begin
            p   = longint'(sa) * longint'(sb);
            res = p[31:0];
            exc = (p != longint'(int'(p)));
        end else if (b == 32'h0) begin
            res = 32'h0;
            exc = 1'b1;
        end else if (a == INT_MIN && b == 32'hFFFF_FFFF) begin
            res = INT_MIN;
            exc = 1'b1;
        end else begin
            res = 32'(sa / sb);
            exc = 1'b0;
        end
    endfunction

    function automatic logic [31:0] pickOperand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'h0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = INT_MIN;
            3:       v = 32'($urandom_range(0, 31)) - 32'd16;
            4:       v = 32'h7FFF_FFFF;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Present a start for one rising edge, then scramble the operands.
    task automatic applyStimulus(input bit mult, input bit div, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_MULT     = mult;
        ctrl_DIV      = div;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic waitReady(input int limit, output int latency);
        latency = -1;
        for (int n = 1; n <= limit; n++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                latency = n;
                break;
            end
        end
    endtask

    task automatic runOp(input string tag, input bit is_div, input logic [31:0] a, input logic [31:0] b,
                         input bit check_width);
        logic [31:0] er;
        logic        ee;
        int          lat;
        modelOp(is_div, a, b, er, ee);
        applyStimulus(!is_div, is_div, a, b);
        waitReady(LAT + 8, lat);
        checkOutput({tag, "_latency"}, 64'(lat), 64'(LAT));
        checkOutput({tag, "_result"}, 64'(data_result), 64'(er));
        checkOutput({tag, "_exception"}, 64'(data_exception), 64'(ee));
        last_res = er;
        last_exc = ee;
        if (check_width) begin
            @(posedge clock);
            #1;
            checkOutput({tag, "_strobe_width"}, 64'(data_resultRDY), 64'd0);
        end
    endtask

    initial begin
        int seen;
        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'h0;
        data_operandB = 32'h0;
        last_res      = 32'h0;
        last_exc      = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_result", 64'(data_result), 64'd0);
        checkOutput("reset_exception", 64'(data_exception), 64'd0);
        checkOutput("reset_ready", 64'(data_resultRDY), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        runOp("mul_6x7", 1'b0, 32'd6, 32'd7, 1'b1);
        runOp("div_m8_3", 1'b1, 32'hFFFF_FFF8, 32'd3, 1'b1);
        runOp("div_by_zero", 1'b1, 32'd7, 32'd0, 1'b1);
        runOp("mul_overflow", 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b1);
        runOp("div_min_m1", 1'b1, INT_MIN, 32'hFFFF_FFFF, 1'b1);

        // Restart: a divide issued 10 edges into a multiply replaces it.
        applyStimulus(1'b1, 1'b0, 32'd3, 32'd5);
        seen = 0;
        repeat (9) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) seen++;
        end
        runOp("restart_div", 1'b1, 32'd100, 32'd7, 1'b1);
        checkOutput("restart_no_early_strobe", 64'(seen), 64'd0);

        // Both strobes together are ignored.
        @(negedge clock);
        ctrl_MULT     = 1'b1;
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'd9;
        seen = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) seen++;
        end
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        checkOutput("both_high_no_strobe", 64'(seen), 64'd0);
        checkOutput("both_high_result_held", 64'(data_result), 64'(last_res));
        checkOutput("both_high_exception_held", 64'(data_exception), 64'(last_exc));

        // Reset in the middle of an operation aborts it silently.
        applyStimulus(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h7FFF_FFFF);
        repeat (14) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("midreset_result", 64'(data_result), 64'd0);
        checkOutput("midreset_exception", 64'(data_exception), 64'd0);
        checkOutput("midreset_ready", 64'(data_resultRDY), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) seen++;
        end
        checkOutput("midreset_no_strobe", 64'(seen), 64'd0);

        // Back-to-back: the second start lands in the DONE cycle.
        runOp("b2b_first", 1'b0, 32'd6, 32'd7, 1'b0);
        runOp("b2b_second", 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            bit          is_div;
            logic [31:0] a;
            logic [31:0] b;
            is_div = 1'($urandom_range(0, 1));
            a      = pickOperand();
            b      = pickOperand();
            runOp(is_div ? "rand_div" : "rand_mul", is_div, a, b, (i % 8) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
